// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier (default binary16) with valid/ready
// backpressure, RNE/RTZ rounding, full subnormal support and exception flags.
module fp_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   rnd_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_p,
  output logic [3:0]             out_flags
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- S1: unpack and special-case decode ----------------
  logic [W-1:0]     op [2];
  logic [1:0]       sign_op, zero_op, inf_op, nan_op, snan_op;
  logic [EXP_W-1:0] eexp_op [2];
  logic [MAN_W:0]   man_op [2];

  assign op[0] = in_a;
  assign op[1] = in_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      logic [EXP_W-1:0] ef;
      logic [MAN_W-1:0] ff;
      assign ef            = op[gi][W-2 -: EXP_W];
      assign ff            = op[gi][MAN_W-1:0];
      assign sign_op[gi]   = op[gi][W-1];
      assign zero_op[gi]   = (ef == '0) && (ff == '0);
      assign inf_op[gi]    = (&ef) && (ff == '0);
      assign nan_op[gi]    = (&ef) && (ff != '0);
      assign snan_op[gi]   = nan_op[gi] && !ff[MAN_W-1];
      // Subnormals share the minimum exponent but lose the hidden bit.
      assign eexp_op[gi]   = (ef == '0) ? EXP_W'(1) : ef;
      assign man_op[gi]    = {ef != '0, ff};
    end
  endgenerate

  logic                  s1_sign_next, s1_spec_next, s1_inv_next;
  logic [W-1:0]          s1_spec_p_next;
  logic signed [EW2-1:0] s1_exp_next;
  logic                  inv_mul;

  assign inv_mul      = (inf_op[0] & zero_op[1]) | (zero_op[0] & inf_op[1]);
  assign s1_sign_next = sign_op[0] ^ sign_op[1];
  assign s1_exp_next  = EW2'(int'(eexp_op[0]) + int'(eexp_op[1]) - BIAS);

  always_comb begin
    s1_spec_next   = 1'b0;
    s1_inv_next    = 1'b0;
    s1_spec_p_next = '0;
    if ((|nan_op) || inv_mul) begin
      s1_spec_next   = 1'b1;
      s1_inv_next    = (|snan_op) || inv_mul;
      s1_spec_p_next = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (|inf_op) begin
      s1_spec_next   = 1'b1;
      s1_spec_p_next = {s1_sign_next, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (|zero_op) begin
      s1_spec_next   = 1'b1;
      s1_spec_p_next = {s1_sign_next, {(W-1){1'b0}}};
    end
  end

  logic                  s1_valid_reg, s1_sign_reg, s1_spec_reg, s1_inv_reg, s1_rnd_reg;
  logic [W-1:0]          s1_spec_p_reg;
  logic signed [EW2-1:0] s1_exp_reg;
  logic [MAN_W:0]        s1_ma_reg, s1_mb_reg;

  // ---------------- S2: mantissa product and bounded normalise ----------------
  logic [PW-1:0]         prod;
  logic [PW-1:0]         s2_man_next;
  logic signed [EW2-1:0] s2_exp_next;
  int                    lz, lim, kshift, esum;

  assign prod = PW'(s1_ma_reg) * PW'(s1_mb_reg);

  always_comb begin
    lz = PW;
    for (int i = 0; i < PW; i++) begin
      if (prod[i]) lz = PW - 1 - i;
    end
    esum = int'(s1_exp_reg);
    // Leading one sits at the top bit with exponent esum+1; never shift below exponent 1.
    lim         = (esum > 0) ? esum : 0;
    kshift      = (lz < lim) ? lz : lim;
    s2_man_next = prod << kshift;
    s2_exp_next = EW2'(esum + 1 - kshift);
  end

  logic                  s2_valid_reg, s2_sign_reg, s2_spec_reg, s2_inv_reg, s2_rnd_reg;
  logic [W-1:0]          s2_spec_p_reg;
  logic signed [EW2-1:0] s2_exp_reg;
  logic [PW-1:0]         s2_man_reg;

  // ---------------- S3: denormalise, round, pack ----------------
  int              en, sh, ebase, er;
  logic [2*PW-1:0] wide;
  logic [PW-1:0]   ms;
  logic [MAN_W:0]  kept;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] frac_r;
  logic            g_bit, r_bit, s_bit, inc, tiny, lost, normal, ovf;
  logic [W-1:0]    p_next;
  logic [3:0]      flags_next;

  always_comb begin
    en = int'(s2_exp_reg);
    sh = (en < 1) ? (1 - en) : 0;
    if (sh > PW + 1) sh = PW + 1;
    wide  = {s2_man_reg, {PW{1'b0}}} >> sh;
    ms    = wide[2*PW-1:PW];
    kept  = ms[PW-1 -: MAN_W+1];
    g_bit = ms[MAN_W];
    r_bit = ms[MAN_W-1];
    s_bit = (|ms[MAN_W-2:0]) | (|wide[PW-1:0]);
    inc   = !s2_rnd_reg && g_bit && (r_bit || s_bit || kept[0]);
    mr    = {1'b0, kept} + (MAN_W+2)'(inc);
    tiny  = !ms[PW-1];
    lost  = g_bit | r_bit | s_bit;
    ebase = (en < 1) ? 1 : en;
    if (mr[MAN_W+1]) begin
      er     = ebase + 1;
      frac_r = mr[MAN_W:1];
      normal = 1'b1;
    end else begin
      er     = ebase;
      frac_r = mr[MAN_W-1:0];
      normal = mr[MAN_W];
    end
    ovf = normal && (er >= EMAX);

    if (s2_spec_reg) begin
      p_next     = s2_spec_p_reg;
      flags_next = {s2_inv_reg, 3'b000};
    end else if (ovf) begin
      p_next     = s2_rnd_reg ? {s2_sign_reg, EXP_W'(EMAX - 1), {MAN_W{1'b1}}}
                              : {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_next = 4'b0101;
    end else begin
      p_next     = {s2_sign_reg, normal ? EXP_W'(er) : {EXP_W{1'b0}}, frac_r};
      flags_next = {2'b00, tiny & lost, lost};
    end
  end

  // Every stage moves together on adv, so a stalled output freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      out_valid    <= 1'b0;
      out_p        <= '0;
      out_flags    <= '0;
    end else if (adv) begin
      s1_valid_reg  <= in_valid;
      s1_sign_reg   <= s1_sign_next;
      s1_exp_reg    <= s1_exp_next;
      s1_ma_reg     <= man_op[0];
      s1_mb_reg     <= man_op[1];
      s1_spec_reg   <= s1_spec_next;
      s1_spec_p_reg <= s1_spec_p_next;
      s1_inv_reg    <= s1_inv_next;
      s1_rnd_reg    <= rnd_mode;

      s2_valid_reg  <= s1_valid_reg;
      s2_sign_reg   <= s1_sign_reg;
      s2_exp_reg    <= s2_exp_next;
      s2_man_reg    <= s2_man_next;
      s2_spec_reg   <= s1_spec_reg;
      s2_spec_p_reg <= s1_spec_p_reg;
      s2_inv_reg    <= s1_inv_reg;
      s2_rnd_reg    <= s1_rnd_reg;

      out_valid     <= s2_valid_reg;
      out_p         <= p_next;
      out_flags     <= flags_next;
    end
  end
endmodule
